// File: rtl/if_fetch_if.sv
// if_fetch_if: bundles the fetch stage's redirect, ID-side and instruction
// memory signals. The fetch stage connects through the master modport and
// its environment (EX/ID/IMEM, or a bench) connects through the slave modport.
interface if_fetch_if;
  // Redirect from EX
  logic        i_IF_ctrl_PCSrc;
  logic [31:0] i_IF_data_PCBranch;
  // ID side
  logic        i_ID_stall;
  logic        o_ID_valid;
  logic [31:0] o_ID_data_Instr;
  logic [31:0] o_ID_data_PCNext;
  logic        o_ID_ctrl_AdEL;
  // Instruction memory req/ack
  logic        o_IMEM_req;
  logic [31:0] o_IMEM_addr;
  logic        i_IMEM_ack;
  logic [31:0] i_IMEM_rdata;

  modport master (
    input  i_IF_ctrl_PCSrc,
    input  i_IF_data_PCBranch,
    input  i_ID_stall,
    output o_ID_valid,
    output o_ID_data_Instr,
    output o_ID_data_PCNext,
    output o_ID_ctrl_AdEL,
    output o_IMEM_req,
    output o_IMEM_addr,
    input  i_IMEM_ack,
    input  i_IMEM_rdata
  );

  modport slave (
    output i_IF_ctrl_PCSrc,
    output i_IF_data_PCBranch,
    output i_ID_stall,
    input  o_ID_valid,
    input  o_ID_data_Instr,
    input  o_ID_data_PCNext,
    input  o_ID_ctrl_AdEL,
    input  o_IMEM_req,
    input  o_IMEM_addr,
    output i_IMEM_ack,
    output i_IMEM_rdata
  );
endinterface

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage. Owns the PC, runs a req/ack handshake to
// instruction memory, presents a registered instruction plus PC+4 to ID,
// absorbs ID stalls with a one-entry skid buffer and discards wrong-path
// fetches after an EX redirect.
//
// Optional feature macro: IF_ALIGN_CHECK_EN
//   defined   : a misaligned redirect target (or misaligned RESET_PC) issues
//               no fetch; the stage enters ERR and presents one nop with
//               o_ID_ctrl_AdEL=1 and PCNext=badaddr+4 until a new redirect.
//   undefined : redirect target bits [1:0] are forced to 00, AdEL tied 0.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  if_fetch_if.master    bus
);

  // FETCH : request outstanding on addr (or about to issue)
  // FULL  : skid holds one word, ID stalled, no request
  // DROP  : wrong-path request outstanding, its data will be thrown away
  // ERR   : misaligned target reported to ID (align check build only)
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_FULL  = 2'd1,
    S_DROP  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

`ifdef IF_ALIGN_CHECK_EN
  localparam logic RESET_BAD = |RESET_PC[1:0];
`else
  localparam logic RESET_BAD = 1'b0;
`endif

  state_t      state;
  logic [31:0] pc;
  logic [31:0] addr;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc_next;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc_next;
`ifdef IF_ALIGN_CHECK_EN
  logic        adel;
  logic        err_shown;
`endif

  logic        slot_free;
  logic [31:0] addr_inc;
  logic [31:0] tgt;
  logic        tgt_bad;
  logic        pc_bad;
  logic        skid_load;

  // Next sequential word address; wraps modulo 2^32.
  function automatic logic [31:0] inc4(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  // Redirect target as loaded into the PC.
  function automatic logic [31:0] load_target(input logic [31:0] br);
`ifdef IF_ALIGN_CHECK_EN
    return br;
`else
    return br & 32'hFFFF_FFFC;
`endif
  endfunction

  // Handshake decode, next address and redirect target qualification.
  always_comb begin
    slot_free = !valid || !bus.i_ID_stall;
    addr_inc  = inc4(addr);
    tgt       = load_target(bus.i_IF_data_PCBranch);
`ifdef IF_ALIGN_CHECK_EN
    tgt_bad   = |bus.i_IF_data_PCBranch[1:0];
    pc_bad    = |pc[1:0];
`else
    tgt_bad   = 1'b0;
    pc_bad    = 1'b0;
`endif
    skid_load = !bus.i_IF_ctrl_PCSrc && (state == S_FETCH) &&
                bus.i_IMEM_ack && !slot_free;
  end

  // Fetch FSM: PC, request address, ID output register; redirect wins over all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RESET_BAD ? S_ERR : S_FETCH;
      pc        <= RESET_PC;
      addr      <= RESET_PC;
      valid     <= 1'b0;
      instr     <= 32'h0;
      pc_next   <= 32'h0;
`ifdef IF_ALIGN_CHECK_EN
      adel      <= 1'b0;
      err_shown <= 1'b0;
`endif
    end else if (bus.i_IF_ctrl_PCSrc) begin
      pc    <= tgt;
      valid <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
      adel      <= 1'b0;
      err_shown <= 1'b0;
`endif
      case (state)
        S_FETCH: begin
          if (bus.i_IMEM_ack) begin
            // Wrong-path word arrives now: drop it and restart at the target.
            addr  <= tgt;
            state <= tgt_bad ? S_ERR : S_FETCH;
          end else begin
            // Address must stay stable until the old request is acked.
            state <= S_DROP;
          end
        end
        S_DROP: begin
          if (bus.i_IMEM_ack) begin
            addr  <= tgt;
            state <= tgt_bad ? S_ERR : S_FETCH;
          end
        end
        default: begin
          // FULL or ERR: no request in flight, restart immediately.
          addr  <= tgt;
          state <= tgt_bad ? S_ERR : S_FETCH;
        end
      endcase
    end else begin
      case (state)
        S_FETCH: begin
          if (bus.i_IMEM_ack) begin
            pc   <= addr_inc;
            addr <= addr_inc;
            if (slot_free) begin
              instr   <= bus.i_IMEM_rdata;
              pc_next <= addr_inc;
              valid   <= 1'b1;
            end else begin
              state <= S_FULL;
            end
          end else if (slot_free) begin
            valid <= 1'b0;
          end
        end
        S_FULL: begin
          if (!bus.i_ID_stall) begin
            instr   <= skid_instr;
            pc_next <= skid_pc_next;
            valid   <= 1'b1;
            state   <= S_FETCH;
          end
        end
        S_DROP: begin
          if (bus.i_IMEM_ack) begin
            addr  <= pc;
            state <= pc_bad ? S_ERR : S_FETCH;
          end
        end
`ifdef IF_ALIGN_CHECK_EN
        S_ERR: begin
          if (!err_shown) begin
            valid     <= 1'b1;
            instr     <= 32'h0;
            pc_next   <= inc4(pc);
            adel      <= 1'b1;
            err_shown <= 1'b1;
          end else if (valid && !bus.i_ID_stall) begin
            valid <= 1'b0;
            adel  <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Skid entry: captures the word acked while ID is stalled.
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_instr   <= bus.i_IMEM_rdata;
      skid_pc_next <= addr_inc;
    end
  end

  assign bus.o_IMEM_req       = (state == S_FETCH) || (state == S_DROP);
  assign bus.o_IMEM_addr      = addr;
  assign bus.o_ID_valid       = valid;
  assign bus.o_ID_data_Instr  = instr;
  assign bus.o_ID_data_PCNext = pc_next;
`ifdef IF_ALIGN_CHECK_EN
  assign bus.o_ID_ctrl_AdEL   = adel;
`else
  assign bus.o_ID_ctrl_AdEL   = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed bench for if_fetch. A per-cycle vector table runs the
// zero-wait pipeline, stall/skid, redirect and wrap cases; short hand-written
// sequences cover the slow-memory DROP cases and the alignment option.
module tb_if_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   lat = 0;
  int   wcnt = 0;
  int   total = 0;
  int   bad = 0;

  if_fetch_if bus();

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return a ^ 32'hC0DE_0000;
  endfunction

  // Instruction memory: ack arrives after 'lat' waiting cycles (0 = same cycle).
  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (bus.i_IMEM_ack) wcnt <= 0;
    else if (bus.o_IMEM_req) wcnt <= wcnt + 1;
  end

  always_comb begin
    bus.i_IMEM_ack   = bus.o_IMEM_req && (wcnt >= lat);
    bus.i_IMEM_rdata = mem_word(bus.o_IMEM_addr);
  end

  typedef struct {
    logic        stall;
    logic        pcsrc;
    logic [31:0] br;
    logic        v;
    logic [31:0] instr;
    logic [31:0] pn;
    logic        req;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1;
    lat = l;
    bus.i_IF_ctrl_PCSrc    = 1'b0;
    bus.i_IF_data_PCBranch = 32'h0;
    bus.i_ID_stall         = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] br);
    bus.i_IF_ctrl_PCSrc    = 1'b1;
    bus.i_IF_data_PCBranch = br;
    cycle();
    bus.i_IF_ctrl_PCSrc    = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 10; i++) begin
      if (bus.o_ID_valid) break;
      cycle();
    end
    chk(name, {31'h0, bus.o_ID_valid}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    // stall pcsrc br            v  instr                  pn            req addr
    tbl[0]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h2008_0005,        32'h4,        1'b1, 32'h4};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, mem_word(32'h4),      32'h8,        1'b1, 32'h8};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, mem_word(32'h8),      32'hC,        1'b1, 32'hC};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,         1'b1, mem_word(32'h8),      32'hC,        1'b0, 32'h10};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,         1'b1, mem_word(32'h8),      32'hC,        1'b0, 32'h10};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,         1'b1, mem_word(32'h8),      32'hC,        1'b0, 32'h10};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, mem_word(32'hC),      32'h10,       1'b1, 32'h10};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,         1'b1, mem_word(32'h10),     32'h14,       1'b1, 32'h14};
    tbl[8]  = '{1'b1, 1'b1, 32'h40,        1'b0, 32'h0,                32'h0,        1'b1, 32'h40};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,         1'b1, mem_word(32'h40),     32'h44,       1'b1, 32'h44};
    tbl[10] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,                32'h0,        1'b1, 32'hFFFF_FFFC};
    tbl[11] = '{1'b0, 1'b0, 32'h0,         1'b1, mem_word(32'hFFFF_FFFC), 32'h0,     1'b1, 32'h0};
    tbl[12] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h2008_0005,        32'h4,        1'b1, 32'h4};

    // Reset state with zero-wait memory
    do_reset(0);
    chk("rst_valid", {31'h0, bus.o_ID_valid}, 32'h0);
    chk("rst_instr", bus.o_ID_data_Instr, 32'h0);
    chk("rst_pcnext", bus.o_ID_data_PCNext, 32'h0);
    chk("rst_addr", bus.o_IMEM_addr, 32'h0);
    chk("rst_req", {31'h0, bus.o_IMEM_req}, 32'h1);
    chk("rst_adel", {31'h0, bus.o_ID_ctrl_AdEL}, 32'h0);

    // Table: streaming, stall/skid, redirect with ack+stall, wrap-around
    for (int i = 0; i < 13; i++) begin
      bus.i_ID_stall         = tbl[i].stall;
      bus.i_IF_ctrl_PCSrc    = tbl[i].pcsrc;
      bus.i_IF_data_PCBranch = tbl[i].br;
      cycle();
      chk($sformatf("v%0d_valid", i), {31'h0, bus.o_ID_valid}, {31'h0, tbl[i].v});
      chk($sformatf("v%0d_req", i), {31'h0, bus.o_IMEM_req}, {31'h0, tbl[i].req});
      chk($sformatf("v%0d_addr", i), bus.o_IMEM_addr, tbl[i].addr);
      chk($sformatf("v%0d_adel", i), {31'h0, bus.o_ID_ctrl_AdEL}, 32'h0);
      if (tbl[i].v) begin
        chk($sformatf("v%0d_instr", i), bus.o_ID_data_Instr, tbl[i].instr);
        chk($sformatf("v%0d_pcnext", i), bus.o_ID_data_PCNext, tbl[i].pn);
      end
    end
    bus.i_IF_ctrl_PCSrc = 1'b0;
    bus.i_ID_stall      = 1'b0;

    // Slow memory: redirect during the first wait cycle drops the old word
    do_reset(2);
    redirect(32'h100);
    chk("dropA_addr1", bus.o_IMEM_addr, 32'h0);
    chk("dropA_req1", {31'h0, bus.o_IMEM_req}, 32'h1);
    chk("dropA_valid1", {31'h0, bus.o_ID_valid}, 32'h0);
    cycle();
    chk("dropA_addr2", bus.o_IMEM_addr, 32'h0);
    chk("dropA_valid2", {31'h0, bus.o_ID_valid}, 32'h0);
    cycle();
    chk("dropA_valid3", {31'h0, bus.o_ID_valid}, 32'h0);
    chk("dropA_newaddr", bus.o_IMEM_addr, 32'h100);
    chk("dropA_req3", {31'h0, bus.o_IMEM_req}, 32'h1);
    wait_valid("dropA_wait");
    chk("dropA_instr", bus.o_ID_data_Instr, mem_word(32'h100));
    chk("dropA_pcnext", bus.o_ID_data_PCNext, 32'h104);

    // DROP: latest redirect wins; redirect coinciding with the ack
    do_reset(2);
    redirect(32'h100);
    redirect(32'h180);
    cycle();
    chk("dropC_latest", bus.o_IMEM_addr, 32'h180);
    redirect(32'h1C0);
    cycle();
    chk("dropC_hold", bus.o_IMEM_addr, 32'h180);
    redirect(32'h1E0);
    chk("dropC_ackredir", bus.o_IMEM_addr, 32'h1E0);
    chk("dropC_valid", {31'h0, bus.o_ID_valid}, 32'h0);
    wait_valid("dropC_wait");
    chk("dropC_pcnext", bus.o_ID_data_PCNext, 32'h1E4);
    chk("dropC_instr", bus.o_ID_data_Instr, mem_word(32'h1E0));

    // Redirect + ack + stall while output holds PC 8, then redirect from FULL
    do_reset(0);
    cycle();
    cycle();
    chk("seqB_pc8", bus.o_ID_data_PCNext, 32'h8);
    bus.i_ID_stall = 1'b1;
    redirect(32'h200);
    chk("seqB_flush", {31'h0, bus.o_ID_valid}, 32'h0);
    chk("seqB_addr", bus.o_IMEM_addr, 32'h200);
    chk("seqB_req", {31'h0, bus.o_IMEM_req}, 32'h1);
    cycle();
    chk("seqB_valid", {31'h0, bus.o_ID_valid}, 32'h1);
    chk("seqB_pcnext", bus.o_ID_data_PCNext, 32'h204);
    cycle();
    chk("seqB_full_req", {31'h0, bus.o_IMEM_req}, 32'h0);
    chk("seqB_full_hold", bus.o_ID_data_PCNext, 32'h204);
    redirect(32'h300);
    chk("seqB_fullredir_v", {31'h0, bus.o_ID_valid}, 32'h0);
    chk("seqB_fullredir_addr", bus.o_IMEM_addr, 32'h300);
    chk("seqB_fullredir_req", {31'h0, bus.o_IMEM_req}, 32'h1);
    bus.i_ID_stall = 1'b0;

`ifdef IF_ALIGN_CHECK_EN
    // Misaligned redirect reports AdEL and stops fetching until re-redirected
    do_reset(0);
    redirect(32'h102);
    chk("al_req0", {31'h0, bus.o_IMEM_req}, 32'h0);
    cycle();
    chk("al_valid", {31'h0, bus.o_ID_valid}, 32'h1);
    chk("al_adel", {31'h0, bus.o_ID_ctrl_AdEL}, 32'h1);
    chk("al_instr", bus.o_ID_data_Instr, 32'h0);
    chk("al_pcnext", bus.o_ID_data_PCNext, 32'h106);
    bus.i_ID_stall = 1'b1;
    cycle();
    cycle();
    chk("al_hold_v", {31'h0, bus.o_ID_valid}, 32'h1);
    chk("al_hold_pn", bus.o_ID_data_PCNext, 32'h106);
    chk("al_hold_adel", {31'h0, bus.o_ID_ctrl_AdEL}, 32'h1);
    chk("al_hold_req", {31'h0, bus.o_IMEM_req}, 32'h0);
    bus.i_ID_stall = 1'b0;
    cycle();
    chk("al_acc_v", {31'h0, bus.o_ID_valid}, 32'h0);
    cycle();
    chk("al_stay_req", {31'h0, bus.o_IMEM_req}, 32'h0);
    redirect(32'h200);
    chk("al_resume_req", {31'h0, bus.o_IMEM_req}, 32'h1);
    chk("al_resume_addr", bus.o_IMEM_addr, 32'h200);
    chk("al_resume_adel", {31'h0, bus.o_ID_ctrl_AdEL}, 32'h0);
    cycle();
    chk("al_resume_pn", bus.o_ID_data_PCNext, 32'h204);
`else
    // Low target bits are ignored when no alignment check is built in
    do_reset(0);
    redirect(32'h502);
    chk("mask_addr", bus.o_IMEM_addr, 32'h500);
    cycle();
    chk("mask_pcnext", bus.o_ID_data_PCNext, 32'h504);
    chk("mask_instr", bus.o_ID_data_Instr, mem_word(32'h500));
    chk("mask_adel", {31'h0, bus.o_ID_ctrl_AdEL}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
